// File: rtl/exception_ctrl_pkg.sv
// Shared constants and types for the memory-stage exception arbiter.
// Holds exception codes, CP0 register numbers and the FSM encoding.
package exception_ctrl_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_TR   = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DRAIN  = 2'd2
    } exc_state_e;

    typedef struct packed {
        logic [7:0]  im;
        logic        exl;
        logic        ie;
        logic [7:0]  ip;
        logic [31:0] epc;
    } cp0_view_t;

    // Only the CP0 fields the arbiter consumes, with the WB mtc0 forwarded.
    function automatic cp0_view_t cp0_bypass(
        input logic [31:0] status,
        input logic [31:0] cause,
        input logic [31:0] epc,
        input logic        we,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        cp0_view_t   v;
        logic [31:0] st;
        st = (we && waddr == CP0_STATUS) ? wdata : status;
        v.im  = st[15:8];
        v.exl = st[1];
        v.ie  = st[0];
        v.ip  = cause[15:8];
        if (we && waddr == CP0_CAUSE)
            v.ip[1:0] = wdata[9:8];
        v.epc = (we && waddr == CP0_EPC) ? wdata : epc;
        return v;
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Bundle between the mem stage / CP0 and the exception arbiter.
// master drives the stage-side inputs, slave is the arbiter itself.
interface exception_ctrl_if;
    logic        valid_i;
    logic        stall_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic        exc_adel_if_i;
    logic        exc_ri_i;
    logic        exc_ov_i;
    logic        exc_trap_i;
    logic        exc_sys_i;
    logic        exc_bp_i;
    logic        exc_adel_mem_i;
    logic        exc_ades_mem_i;
    logic        eret_i;
    logic [31:0] mem_addr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [5:0]  int_i;
    logic [5:0]  int_sync_o;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output valid_i, stall_i, pc_i, in_delayslot_i,
        output exc_adel_if_i, exc_ri_i, exc_ov_i, exc_trap_i,
        output exc_sys_i, exc_bp_i, exc_adel_mem_i,
        output exc_ades_mem_i, eret_i, mem_addr_i,
        output status_i, cause_i, epc_i,
        output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output int_i,
        input  int_sync_o, excepttype_o, current_inst_addr_o,
        input  is_in_delayslot_o, bad_addr_o, flush_o, new_pc_o
    );

    modport slave (
        input  valid_i, stall_i, pc_i, in_delayslot_i,
        input  exc_adel_if_i, exc_ri_i, exc_ov_i, exc_trap_i,
        input  exc_sys_i, exc_bp_i, exc_adel_mem_i,
        input  exc_ades_mem_i, eret_i, mem_addr_i,
        input  status_i, cause_i, epc_i,
        input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  int_i,
        output int_sync_o, excepttype_o, current_inst_addr_o,
        output is_in_delayslot_o, bad_addr_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/exception_ctrl_int_sync.sv
// N-deep flop chain bringing asynchronous interrupt lines into clk.
// Chain is cleared by the synchronous reset.
module int_sync #(
    parameter int W = 6,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [N-1:0][W-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst)
            ff <= '0;
        else
            ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/exception_ctrl.sv
// Memory-stage exception arbiter: resolves priority, pulses CP0,
// flushes the pipeline and then blanks detection while it drains.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          SYNC_STAGES  = 2
) (
    input logic             clk,
    input logic             rst,
    exception_ctrl_if.slave bus
);

    exc_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    cp0_view_t   cp0;
    logic        int_pend;
    logic        any_exc;
    logic        detect;
    logic [31:0] code_d;
    logic        bad_pc;
    logic        bad_mem;
    logic [31:0] type_q;
    logic [31:0] npc_q;
    logic [31:0] cia_q;
    logic        ds_q;
    logic [31:0] bad_q;

    int_sync #(
        .W (6),
        .N (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.int_i),
        .q   (bus.int_sync_o)
    );

    assign cp0 = cp0_bypass(bus.status_i, bus.cause_i,
                            bus.epc_i, bus.wb_cp0_we_i,
                            bus.wb_cp0_waddr_i,
                            bus.wb_cp0_data_i);

    assign int_pend = cp0.ie & ~cp0.exl & |(cp0.ip & cp0.im);

    assign any_exc = int_pend | bus.exc_adel_if_i
                   | bus.exc_ri_i | bus.exc_ov_i
                   | bus.exc_trap_i | bus.exc_sys_i
                   | bus.exc_bp_i | bus.exc_adel_mem_i
                   | bus.exc_ades_mem_i | bus.eret_i;

    assign detect = (state_q == ST_IDLE) & bus.valid_i
                  & ~bus.stall_i & any_exc;

    always_comb begin
        code_d  = '0;
        bad_pc  = 1'b0;
        bad_mem = 1'b0;
        priority case (1'b1)
            int_pend:           code_d = EXC_INT;
            bus.exc_adel_if_i: begin
                code_d = EXC_ADEL;
                bad_pc = 1'b1;
            end
            bus.exc_ri_i:       code_d = EXC_RI;
            bus.exc_ov_i:       code_d = EXC_OV;
            bus.exc_trap_i:     code_d = EXC_TR;
            bus.exc_sys_i:      code_d = EXC_SYS;
            bus.exc_bp_i:       code_d = EXC_BP;
            bus.exc_adel_mem_i: begin
                code_d  = EXC_ADEL;
                bad_mem = 1'b1;
            end
            bus.exc_ades_mem_i: begin
                code_d  = EXC_ADES;
                bad_mem = 1'b1;
            end
            bus.eret_i:         code_d = EXC_ERET;
            default:            code_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (detect)
                    state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_DRAIN;
                cnt_d   = 3'(DRAIN_CYCLES - 1);
            end
            ST_DRAIN: begin
                if (cnt_q == 3'd0)
                    state_d = ST_IDLE;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Captured at the detection edge; bad address keeps its last value
    // unless this exception carries a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            type_q <= '0;
            npc_q  <= '0;
            cia_q  <= '0;
            ds_q   <= 1'b0;
            bad_q  <= '0;
        end else if (detect) begin
            type_q <= code_d;
            npc_q  <= (code_d == EXC_ERET) ? cp0.epc : EXC_VECTOR;
            cia_q  <= bus.pc_i;
            ds_q   <= bus.in_delayslot_i;
            if (bad_pc)
                bad_q <= bus.pc_i;
            else if (bad_mem)
                bad_q <= bus.mem_addr_i;
        end
    end

    always_comb begin
        bus.flush_o             = (state_q == ST_COMMIT);
        bus.excepttype_o        = bus.flush_o ? type_q : '0;
        bus.new_pc_o            = bus.flush_o ? npc_q : '0;
        bus.current_inst_addr_o = cia_q;
        bus.is_in_delayslot_o   = ds_q;
        bus.bad_addr_o          = bad_q;
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed cases plus random
// traffic compared every cycle against a behavioural model.
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int DRAIN = 2;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    exception_ctrl_if bus();

    exception_ctrl #(
        .EXC_VECTOR   (VEC),
        .DRAIN_CYCLES (DRAIN),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model state: expected outputs for the next cycle
    logic [31:0] m_type, m_npc, m_cia, m_bad;
    logic        m_flush, m_ds;
    logic [5:0]  m_sync;
    logic [5:0]  hist[$];
    int          blank;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_type = '0; m_npc = '0; m_cia = '0; m_bad = '0;
        m_flush = 1'b0; m_ds = 1'b0; m_sync = '0;
        blank = 0;
        hist.delete();
        for (int i = 0; i < SYNC - 1; i++) hist.push_back(6'd0);
    endtask

    task automatic model_step();
        logic [31:0] st, ca, ep;
        bit          irq;
        bit          src[10];
        logic [31:0] codes[10];
        int          hit;
        if (rst) begin
            model_reset();
            return;
        end
        m_sync = hist.pop_front();
        hist.push_back(bus.int_i);
        st = bus.status_i;
        ca = bus.cause_i;
        ep = bus.epc_i;
        if (bus.wb_cp0_we_i) begin
            if (bus.wb_cp0_waddr_i == 5'd12) st = bus.wb_cp0_data_i;
            if (bus.wb_cp0_waddr_i == 5'd13)
                ca[9:8] = bus.wb_cp0_data_i[9:8];
            if (bus.wb_cp0_waddr_i == 5'd14) ep = bus.wb_cp0_data_i;
        end
        irq = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
        src = '{irq, bus.exc_adel_if_i, bus.exc_ri_i, bus.exc_ov_i,
                bus.exc_trap_i, bus.exc_sys_i, bus.exc_bp_i,
                bus.exc_adel_mem_i, bus.exc_ades_mem_i, bus.eret_i};
        codes = '{32'h1, 32'h4, 32'hA, 32'hC, 32'hD,
                  32'h8, 32'h9, 32'h4, 32'h5, 32'hE};
        hit = -1;
        for (int i = 0; i < 10; i++)
            if (src[i] && hit < 0) hit = i;
        m_type = '0; m_flush = 1'b0; m_npc = '0;
        if (blank > 0) begin
            blank--;
        end else if (bus.valid_i && !bus.stall_i && hit >= 0) begin
            m_type  = codes[hit];
            m_flush = 1'b1;
            m_npc   = (hit == 9) ? ep : VEC;
            m_cia   = bus.pc_i;
            m_ds    = bus.in_delayslot_i;
            if (hit == 1) m_bad = bus.pc_i;
            else if (hit == 7 || hit == 8) m_bad = bus.mem_addr_i;
            blank = 1 + DRAIN;
        end
    endtask

    // advance one cycle and compare every output with the model
    task automatic step();
        model_step();
        @(negedge clk);
        chk("excepttype", bus.excepttype_o, m_type);
        chk("flush", 32'(bus.flush_o), 32'(m_flush));
        chk("new_pc", bus.new_pc_o, m_npc);
        chk("inst_addr", bus.current_inst_addr_o, m_cia);
        chk("delayslot", 32'(bus.is_in_delayslot_o), 32'(m_ds));
        chk("bad_addr", bus.bad_addr_o, m_bad);
        chk("int_sync", 32'(bus.int_sync_o), 32'(m_sync));
    endtask

    task automatic clr();
        bus.valid_i = 0; bus.stall_i = 0; bus.pc_i = '0;
        bus.in_delayslot_i = 0; bus.exc_adel_if_i = 0;
        bus.exc_ri_i = 0; bus.exc_ov_i = 0; bus.exc_trap_i = 0;
        bus.exc_sys_i = 0; bus.exc_bp_i = 0;
        bus.exc_adel_mem_i = 0; bus.exc_ades_mem_i = 0;
        bus.eret_i = 0; bus.mem_addr_i = '0;
        bus.status_i = '0; bus.cause_i = '0; bus.epc_i = '0;
        bus.wb_cp0_we_i = 0; bus.wb_cp0_waddr_i = '0;
        bus.wb_cp0_data_i = '0; bus.int_i = '0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) step();
    endtask

    task automatic rand_inputs();
        logic [4:0] wa[4];
        bus.valid_i = ($urandom_range(0, 9) != 0);
        bus.stall_i = ($urandom_range(0, 4) == 0);
        bus.pc_i = $urandom;
        bus.in_delayslot_i = 1'($urandom);
        bus.exc_adel_if_i  = ($urandom_range(0, 15) == 0);
        bus.exc_ri_i       = ($urandom_range(0, 15) == 0);
        bus.exc_ov_i       = ($urandom_range(0, 15) == 0);
        bus.exc_trap_i     = ($urandom_range(0, 15) == 0);
        bus.exc_sys_i      = ($urandom_range(0, 15) == 0);
        bus.exc_bp_i       = ($urandom_range(0, 15) == 0);
        bus.exc_adel_mem_i = ($urandom_range(0, 15) == 0);
        bus.exc_ades_mem_i = ($urandom_range(0, 15) == 0);
        bus.eret_i         = ($urandom_range(0, 15) == 0);
        bus.mem_addr_i = $urandom;
        bus.status_i = $urandom;
        bus.status_i[1] = ($urandom_range(0, 3) == 0);
        bus.cause_i = $urandom & ~32'h0000_FF00;
        if ($urandom_range(0, 3) == 0)
            bus.cause_i[15:8] = 8'($urandom);
        bus.epc_i = $urandom;
        wa = '{5'd12, 5'd13, 5'd14, 5'($urandom)};
        bus.wb_cp0_we_i = ($urandom_range(0, 2) == 0);
        bus.wb_cp0_waddr_i = wa[$urandom_range(0, 3)];
        bus.wb_cp0_data_i = $urandom;
        bus.int_i = 6'($urandom);
        rst = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        clr();
        model_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_type", bus.excepttype_o, 32'h0);
        chk("rst_flush", 32'(bus.flush_o), 32'h0);
        chk("rst_sync", 32'(bus.int_sync_o), 32'h0);
        rst = 1'b0;
        idle(2);

        // syscall, then repeated syscall blanked by the drain window
        bus.valid_i = 1; bus.pc_i = 32'hBFC0_1000; bus.exc_sys_i = 1;
        step();
        chk("t1_type", bus.excepttype_o, 32'h8);
        chk("t1_pc", bus.current_inst_addr_o, 32'hBFC0_1000);
        chk("t1_flush", 32'(bus.flush_o), 32'h1);
        chk("t1_newpc", bus.new_pc_o, 32'hBFC0_0380);
        step();
        chk("t1_flush_off", 32'(bus.flush_o), 32'h0);
        chk("t1_newpc_off", bus.new_pc_o, 32'h0);
        chk("t1_pc_hold", bus.current_inst_addr_o, 32'hBFC0_1000);
        step();
        chk("t1_blank1", bus.excepttype_o, 32'h0);
        step();
        chk("t1_blank2", bus.excepttype_o, 32'h0);
        step();
        chk("t1_again", bus.excepttype_o, 32'h8);
        idle(4);

        // interrupt and its masking
        bus.valid_i = 1; bus.cause_i = 32'h0000_0400;
        bus.status_i = 32'h0000_0401;
        step();
        chk("t2_int", bus.excepttype_o, 32'h1);
        idle(4);
        bus.valid_i = 1; bus.cause_i = 32'h0000_0400;
        bus.status_i = 32'h0000_0403;
        step();
        chk("t2_exl", 32'(bus.flush_o), 32'h0);
        bus.status_i = 32'h0000_0400;
        step();
        chk("t2_ie0", bus.excepttype_o, 32'h0);
        idle(2);

        // priority with delay slot
        bus.valid_i = 1; bus.exc_ri_i = 1; bus.exc_ov_i = 1;
        bus.exc_ades_mem_i = 1; bus.in_delayslot_i = 1;
        step();
        chk("t3_type", bus.excepttype_o, 32'hA);
        chk("t3_ds", 32'(bus.is_in_delayslot_o), 32'h1);
        idle(4);

        // address errors
        bus.valid_i = 1; bus.exc_ades_mem_i = 1;
        bus.mem_addr_i = 32'h8000_0003;
        step();
        chk("t4_ades", bus.excepttype_o, 32'h5);
        chk("t4_bad1", bus.bad_addr_o, 32'h8000_0003);
        idle(4);
        bus.valid_i = 1; bus.exc_adel_if_i = 1;
        bus.pc_i = 32'hBFC0_0002;
        step();
        chk("t4_adel", bus.excepttype_o, 32'h4);
        chk("t4_bad2", bus.bad_addr_o, 32'hBFC0_0002);
        idle(4);

        // eret with EPC forwarded from WB
        bus.valid_i = 1; bus.eret_i = 1; bus.epc_i = 32'h100;
        bus.wb_cp0_we_i = 1; bus.wb_cp0_waddr_i = 5'd14;
        bus.wb_cp0_data_i = 32'hBFC0_2000;
        step();
        chk("t5_type", bus.excepttype_o, 32'hE);
        chk("t5_newpc", bus.new_pc_o, 32'hBFC0_2000);
        idle(4);

        // stall holds off the pulse, reset abandons the drain
        bus.valid_i = 1; bus.exc_sys_i = 1; bus.stall_i = 1;
        bus.pc_i = 32'hBFC0_3000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_stall", bus.excepttype_o, 32'h0);
        end
        bus.stall_i = 0;
        step();
        chk("t6_go", bus.excepttype_o, 32'h8);
        clr();
        step();
        rst = 1'b1;
        step();
        chk("t6_rst_pc", bus.current_inst_addr_o, 32'h0);
        chk("t6_rst_type", bus.excepttype_o, 32'h0);
        rst = 1'b0;
        bus.valid_i = 1; bus.exc_sys_i = 1; bus.pc_i = 32'hBFC0_4000;
        step();
        chk("t6_fresh", bus.excepttype_o, 32'h8);
        chk("t6_fresh_pc", bus.current_inst_addr_o, 32'hBFC0_4000);
        idle(4);

        for (int n = 0; n < 4000; n++) begin
            rand_inputs();
            step();
        end
        rst = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
